// File: rtl/spi_slave_port_pkg.sv
// Shared constants for the SPI slave port: register map, status/control bit
// positions and the frame state enumeration.
package spi_slave_port_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int ST_E    = 0;
    localparam int ST_TRDY = 1;
    localparam int ST_RRDY = 2;
    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;

    localparam int CT_IROE  = 0;
    localparam int CT_ITRDY = 1;
    localparam int CT_IRRDY = 2;
    localparam int CT_IE    = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings SCLK, MOSI and SS_n into the clk domain and produces registered
// edge pulses that are time-aligned with the delayed MOSI and SS_n outputs.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic ss_n_i,
    output logic mosi_o,
    output logic ss_n_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_rise_o,
    output logic ss_fall_o
);
    // Edges are ignored until the preset values have flushed out of the
    // chain, so an SS_n held low through reset does not look like a fall.
    localparam int SETTLE = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;
    logic                   mosi_q;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   ss_rise_q;
    logic                   ss_fall_q;
    logic [3:0]             settle_q;
    logic                   settled;
    logic                   sclk_s;
    logic                   ss_s;

    assign settled = (settle_q == 4'(SETTLE));
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s    = ss_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
            settle_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= settled &  sclk_s & ~sclk_prev_q;
            sclk_fall_q <= settled & ~sclk_s &  sclk_prev_q;
            ss_rise_q   <= settled &  ss_s   & ~ss_prev_q;
            ss_fall_q   <= settled & ~ss_s   &  ss_prev_q;
            if (!settled) settle_q <= settle_q + 4'd1;
        end
    end

    assign mosi_o      = mosi_q;
    assign ss_n_o      = ss_prev_q;
    assign sclk_rise_o = sclk_rise_q;
    assign sclk_fall_o = sclk_fall_q;
    assign ss_rise_o   = ss_rise_q;
    assign ss_fall_o   = ss_fall_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with a host register file: rx/tx holding registers,
// status and control registers, and a registered interrupt.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);
    localparam int               CNT_W    = $clog2(DATABITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATABITS - 1);

    logic mosi_s, ss_n_s, sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .sclk_i      (SCLK),
        .mosi_i      (MOSI),
        .ss_n_i      (SS_n),
        .mosi_o      (mosi_s),
        .ss_n_o      (ss_n_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ss_rise_o   (ss_rise),
        .ss_fall_o   (ss_fall)
    );

    spi_state_e          state_q,    state_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [DATABITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATABITS-1:0] tx_shift_q, tx_shift_d;
    logic [DATABITS-1:0] tx_hold_q,  tx_hold_d;
    logic [DATABITS-1:0] rx_hold_q,  rx_hold_d;
    logic                primed_q,   primed_d;
    logic                rrdy_q,     rrdy_d;
    logic                roe_q,      roe_d;
    logic                toe_q,      toe_d;
    logic [3:0]          ctrl_q,     ctrl_d;
    logic [15:0]         rdata_q,    rdata_d;
    logic                irq_q,      irq_d;

    logic        rd_en, wr_en, rx_read, reload, trdy, err;
    logic [15:0] status, rd_val;
    logic        unused_data;

    assign unused_data = ^data_from_cpu[15:DATABITS];

    assign rd_en   = spi_select & ~read_n;
    assign wr_en   = spi_select & ~write_n;
    assign rx_read = rd_en & (mem_addr == ADDR_RXDATA);
    assign trdy    = ~primed_q;
    assign err     = toe_q | roe_q;

    always_comb begin
        status          = '0;
        status[ST_TOE]  = toe_q;
        status[ST_ROE]  = roe_q;
        status[ST_RRDY] = rrdy_q;
        status[ST_TRDY] = trdy;
        status[ST_E]    = err;
        case (mem_addr)
            ADDR_RXDATA:  rd_val = 16'(rx_hold_q);
            ADDR_STATUS:  rd_val = status;
            ADDR_CONTROL: rd_val = 16'(ctrl_q);
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        rx_hold_d  = rx_hold_q;
        primed_d   = primed_q;
        rrdy_d     = rrdy_q;
        roe_d      = roe_q;
        toe_d      = toe_q;
        ctrl_d     = ctrl_q;
        rdata_d    = rdata_q;
        reload     = 1'b0;

        // Host-side clears go first so that byte completion below wins.
        if (rd_en) rdata_d = rd_val;
        if (rx_read) rrdy_d = 1'b0;
        if (wr_en && mem_addr == ADDR_STATUS) begin
            toe_d  = 1'b0;
            roe_d  = 1'b0;
            rrdy_d = 1'b0;
        end
        if (wr_en && mem_addr == ADDR_CONTROL) ctrl_d = data_from_cpu[3:0];

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    reload     = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
                        bit_cnt_d  = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_LAST) begin
                            rx_hold_d = rx_shift_d;
                            rrdy_d    = 1'b1;
                            if (rrdy_q && !rx_read) roe_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == '0) reload = 1'b1;
                        else tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            tx_shift_d = primed_q ? tx_hold_q : '0;
            primed_d   = 1'b0;
        end

        // A write landing on a reload cycle is accepted: the reload already took the old value.
        if (wr_en && mem_addr == ADDR_TXDATA) begin
            if (!primed_q || reload) begin
                tx_hold_d = data_from_cpu[DATABITS-1:0];
                primed_d  = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end

        irq_d = (err & ctrl_q[CT_IE]) | (rrdy_q & ctrl_q[CT_IRRDY]) |
                (trdy & ctrl_q[CT_ITRDY]) | (roe_q & ctrl_q[CT_IROE]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            rx_hold_q  <= '0;
            primed_q   <= 1'b0;
            rrdy_q     <= 1'b0;
            roe_q      <= 1'b0;
            toe_q      <= 1'b0;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            rx_hold_q  <= rx_hold_d;
            primed_q   <= primed_d;
            rrdy_q     <= rrdy_d;
            roe_q      <= roe_d;
            toe_q      <= toe_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign data_to_cpu   = rdata_q;
    assign MISO          = tx_shift_q[DATABITS-1];
    assign MISO_oe       = ~ss_n_s;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = trdy;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: host reads and master-received bytes are
// checked by scoreboard monitors against expectations queued with the stimulus.
module tb_spi_slave_port;
    localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CT = 3'd3;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  mem_addr = '0;
    logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;
    logic [15:0] data_from_cpu = '0;
    logic [15:0] data_to_cpu;
    logic        SCLK = 1'b0, MOSI = 1'b0, SS_n = 1'b1;
    logic        MISO, MISO_oe, irq, dataavailable, readyfordata;

    always #5 clk = ~clk;

    spi_slave_port #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .read_n(read_n),
        .write_n(write_n), .spi_select(spi_select), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(MISO), .MISO_oe(MISO_oe), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata)
    );

    typedef struct { string name; logic [15:0] val; } exp_t;
    exp_t       rd_q[$];
    exp_t       miso_q[$];
    logic [7:0] miso_rx_q[$];
    exp_t       rd_e, mi_e;
    logic [7:0] mi_got;
    logic       rd_fire = 1'b0;
    int         n_chk = 0, n_fail = 0;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_fire <= spi_select & ~read_n;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_q.size() == 0) check("unexpected_read", data_to_cpu, 16'hxxxx);
            else begin
                rd_e = rd_q.pop_front();
                check(rd_e.name, data_to_cpu, rd_e.val);
            end
        end
        while (miso_rx_q.size() > 0) begin
            mi_got = miso_rx_q.pop_front();
            if (miso_q.size() == 0) check("unexpected_miso", 16'(mi_got), 16'hxxxx);
            else begin
                mi_e = miso_q.pop_front();
                check(mi_e.name, 16'(mi_got), mi_e.val);
            end
        end
    end

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_wr(logic [2:0] a, logic [15:0] d);
        @(negedge clk);
        mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1; spi_select = 1'b0;
    endtask

    task automatic host_rd(logic [2:0] a, string name, logic [15:0] exp);
        rd_q.push_back('{name: name, val: exp});
        @(negedge clk);
        mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
        @(negedge clk);
        read_n = 1'b1; spi_select = 1'b0;
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        SS_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic spi_bits(logic [7:0] b, int n, bit keep);
        logic [7:0] r = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = b[7-i];
            wait_clk(HALF);
            r = {r[6:0], MISO};
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        if (keep) miso_rx_q.push_back(r);
    endtask

    task automatic spi_byte(logic [7:0] b, logic [7:0] exp_miso, string name);
        miso_q.push_back('{name: name, val: 16'(exp_miso)});
        spi_bits(b, 8, 1'b1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_data_to_cpu"}, data_to_cpu, 16'h0000);
        check({tag, "_miso"}, 16'(MISO), 16'h0000);
        check({tag, "_miso_oe"}, 16'(MISO_oe), 16'h0000);
        check({tag, "_irq"}, 16'(irq), 16'h0000);
        check({tag, "_dataavailable"}, 16'(dataavailable), 16'h0000);
        check({tag, "_readyfordata"}, 16'(readyfordata), 16'h0001);
    endtask

    task automatic watch_irq();
        int k = 0;
        while (!dataavailable && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("rrdy_rise_seen", 16'(dataavailable), 16'h0001);
        check("irq_lags_rrdy", 16'(irq), 16'h0000);
        @(negedge clk);
        check("irq_after_rrdy", 16'(irq), 16'h0001);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wait_clk(6);
        host_rd(A_ST, "reset_status", 16'h0002);
        host_rd(A_CT, "reset_control", 16'h0000);
        host_rd(3'd5, "unmapped_read", 16'h0000);

        // basic exchange
        host_wr(A_TX, 16'h00A5);
        host_rd(A_ST, "primed_status", 16'h0000);
        ss_low();
        spi_byte(8'h3C, 8'hA5, "miso_a5");
        ss_high();
        host_rd(A_ST, "rrdy_status", 16'h0006);
        host_rd(A_RX, "rx_3c", 16'h003C);
        host_rd(A_ST, "rrdy_cleared", 16'h0002);

        // two bytes, second unprimed, first unread
        host_wr(A_TX, 16'h005A);
        ss_low();
        spi_byte(8'h11, 8'h5A, "miso_5a");
        spi_byte(8'h22, 8'h00, "miso_unprimed");
        ss_high();
        host_rd(A_ST, "roe_status", 16'h000F);
        host_rd(A_RX, "rx_second", 16'h0022);
        host_rd(A_ST, "roe_after_read", 16'h000B);
        host_wr(A_ST, 16'h0000);
        host_rd(A_ST, "roe_cleared", 16'h0002);

        // tx overrun keeps the first value
        host_wr(A_TX, 16'h0077);
        host_wr(A_TX, 16'h0099);
        host_rd(A_ST, "toe_status", 16'h0011);
        host_wr(A_ST, 16'h0000);
        host_rd(A_ST, "toe_cleared", 16'h0000);
        ss_low();
        spi_byte(8'h00, 8'h77, "miso_kept_first");
        ss_high();
        host_rd(A_RX, "rx_zero", 16'h0000);
        host_rd(A_ST, "after_toe_frame", 16'h0002);

        // partial frame then full 0x81
        ss_low();
        spi_bits(8'hFF, 5, 1'b0);
        ss_high();
        host_rd(A_ST, "partial_no_rrdy", 16'h0002);
        ss_low();
        spi_byte(8'h81, 8'h00, "miso_after_partial");
        ss_high();
        host_rd(A_RX, "rx_81", 16'h0081);

        // interrupt on RRDY
        host_wr(A_CT, 16'h0004);
        wait_clk(2);
        check("irq_idle", 16'(irq), 16'h0000);
        ss_low();
        fork
            spi_byte(8'hC3, 8'h00, "miso_irq_frame");
            watch_irq();
        join
        ss_high();
        host_rd(A_RX, "rx_c3", 16'h00C3);
        check("irq_hold_on_read", 16'(irq), 16'h0001);
        @(negedge clk);
        check("irq_low_after_read", 16'(irq), 16'h0000);
        host_wr(A_CT, 16'h0000);

        // reset mid-byte; SS_n held low through reset must not start a frame
        host_wr(A_TX, 16'h00F0);
        ss_low();
        spi_bits(8'hA5, 4, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("midreset");
        wait_clk(HALF);
        spi_bits(8'hFF, 8, 1'b0);
        wait_clk(HALF);
        host_rd(A_ST, "no_frame_after_reset", 16'h0002);
        ss_high();
        host_wr(A_TX, 16'h003E);
        ss_low();
        spi_byte(8'h6B, 8'h3E, "miso_after_reset");
        ss_high();
        host_rd(A_RX, "rx_after_reset", 16'h006B);

        wait_clk(10);
        check("rd_queue_drained", 16'(rd_q.size()), 16'h0000);
        check("miso_queue_drained", 16'(miso_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_port.md
SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter DATABITS, default 8, meaning SPI word width; only 8 is required.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on SCLK, MOSI and SS_n.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 mem_addr  in  3  register address.
REQ-006 read_n, write_n  in  1 each  active-low host strobes.
REQ-007 spi_select  in  1  host chip select.
REQ-008 data_from_cpu  in  16  write data.
REQ-009 data_to_cpu  out  16  registered read data.
REQ-010 SCLK, MOSI, SS_n  in  1 each  asynchronous SPI lines from master.
REQ-011 MISO  out  1  serial data to master.
REQ-012 MISO_oe  out  1  high while the synchronized SS_n is low.
REQ-013 irq, dataavailable, readyfordata  out  1 each  interrupt, RRDY, TRDY.

Function
REQ-014 SPI mode 0, MSB first: MOSI is sampled on synchronized SCLK rise; MISO changes on synchronized SCLK fall.
REQ-015 Supported SCLK rate: at most clk/8; SS_n setup to first SCLK edge: at least 4 clk.
REQ-016 Host access timing: 2-cycle read (data_to_cpu valid in cycle 2) and single-cycle write strobe, both qualified by spi_select.
REQ-017 Register map:
- 0 = rx data (read; clears RRDY).
- 1 = tx data (write).
- 2 = status {TOE[4], ROE[3], RRDY[2], TRDY[1], E[0]}; any write clears TOE, ROE and RRDY.
- 3 = control {iE[3], iRRDY[2], iTRDY[1], iROE[0]}.
- Other addresses read as 0.
REQ-018 States:
- IDLE: SS_n high.
- ACTIVE: SS_n low.
- IDLE->ACTIVE on the synchronized SS_n fall; ACTIVE->IDLE on the synchronized SS_n rise.
REQ-019 On IDLE->ACTIVE:
- bit_cnt <= 0.
- tx_shift loads tx_holding, or 0x00 if tx_holding is not primed.
- Primed flag clears.
REQ-020 In ACTIVE, each SCLK rise:
- rx_shift <= {rx_shift[6:0], MOSI_sync}.
- bit_cnt increments, wrapping 7->0.
REQ-021 On the rise that wraps bit_cnt to 0:
- rx_holding <= completed byte; RRDY <= 1.
- If RRDY was already 1, ROE <= 1 and rx_holding is overwritten.
REQ-022 In ACTIVE, each SCLK fall:
- If bit_cnt==0, tx_shift reloads per REQ-019.
- Otherwise tx_shift shifts left by 1, filling with 0.
REQ-023 MISO SHALL equal tx_shift[7].
REQ-024 TRDY = not primed. A tx write with TRDY=1 loads tx_holding and sets primed. A write with TRDY=0 sets TOE and leaves tx_holding unchanged.
REQ-025 If a reload and a tx write occur in the same cycle, the reload takes the old value and the new write becomes primed.
REQ-026 An SS_n rise mid-byte SHALL discard the partial rx byte, set no flags and reset bit_cnt.
REQ-027 An rx-data read and a byte completion in the same cycle: RRDY stays 1 and ROE is not set.
REQ-028 E = TOE | ROE.
REQ-029 irq is registered: (E&iE)|(RRDY&iRRDY)|(TRDY&iTRDY)|(ROE&iROE).
REQ-030 Latency: RRDY asserts SYNC_STAGES+2 clk after the 8th SCLK rise at the pin.

Reset
REQ-031 While reset_n is low at a clk edge, all registers SHALL clear, with the following outputs:
- data_to_cpu=0, MISO=0, MISO_oe=0, irq=0.
- dataavailable=0, readyfordata=1.
- Synchronizers preset SS_n high and SCLK low.
- State = IDLE.
REQ-032 Reset mid-frame SHALL abandon the frame. After release, the block waits for a fresh SS_n fall before shifting.

Structure
REQ-033 A shared package SHALL hold register address constants, status and control bit indices, and the IDLE/ACTIVE state enumeration.
REQ-034 Sub-module spi_slave_sync SHALL provide the synchronizers and rise/fall edge detection for SCLK and SS_n, plus the synchronized MOSI.

Verification
REQ-035 Host writes 0xA5; master sends 0x3C. Required: master receives 0xA5, rx reads 0x3C, RRDY=1 then 0 after the read.
REQ-036 Two bytes in one frame with no second tx write. Required: second MISO byte is 0x00; ROE=1 if the first byte was unread; rx holds the second byte.
REQ-037 Two tx writes with no frame between them. Required: TOE=1, E=1, tx_holding keeps the first value; a status write clears TOE.
REQ-038 SS_n rises after 5 SCLKs, then a full frame of 0x81. Required: no RRDY after the partial; rx=0x81 after the full frame.
REQ-039 iRRDY=1, byte received. Required: irq high 1 clk after RRDY rises; low 1 clk after the rx read.
REQ-040 reset_n low for 1 clk mid-byte. Required: all REQ-031 values hold next cycle; the next full frame transfers correctly.
